// File: rtl/hack_pkg.sv
// Shared definitions for the Hack ALU arbiter: control-bit positions, FSM encoding,
// common opcodes and the 16-bit gate helpers the ALU is built from.
package hack_pkg;

  localparam int WIDTH = 16;

  // Positions inside ctl = {zx,nx,zy,ny,f,no}
  localparam int CTL_ZX = 5;
  localparam int CTL_NX = 4;
  localparam int CTL_ZY = 3;
  localparam int CTL_NY = 2;
  localparam int CTL_F  = 1;
  localparam int CTL_NO = 0;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_SUB  = 6'b010011;
  localparam logic [5:0] OP_NEG1 = 6'b111010;

  function automatic logic [WIDTH-1:0] and16_gate(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    return a & b;
  endfunction

  function automatic logic [WIDTH-1:0] not16(input logic [WIDTH-1:0] a);
    return ~a;
  endfunction

  // Carry-out is intentionally dropped.
  function automatic logic [WIDTH-1:0] add16(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/hack_alu16.sv
// Purely combinational 16-bit Hack ALU: optional zero/negate on each input,
// AND or ADD, optional output negate, plus zero and negative flags.
module hack_alu16
  import hack_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctl,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] x_z, x_n, y_z, y_n, conj, sum, o;

  assign x_z  = ctl[CTL_ZX] ? '0 : x;
  assign x_n  = ctl[CTL_NX] ? not16(x_z) : x_z;
  assign y_z  = ctl[CTL_ZY] ? '0 : y;
  assign y_n  = ctl[CTL_NY] ? not16(y_z) : y_z;
  assign conj = and16_gate(x_n, y_n);
  assign sum  = add16(x_n, y_n);
  assign o    = ctl[CTL_F] ? sum : conj;
  assign out  = ctl[CTL_NO] ? not16(o) : o;
  assign zr   = (out == '0);
  assign ng   = out[WIDTH-1];

endmodule

// File: rtl/hack_alu_arbiter.sv
// Two-requester front end for one shared Hack ALU: grant, latch operands,
// evaluate for one cycle, then hold a registered result until it is consumed.
module hack_alu_arbiter
  import hack_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [5:0]       req0_ctl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [5:0]       req1_ctl,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_out,
  output logic             resp_zr,
  output logic             resp_ng,
  output logic             busy
);

  if (WIDTH != 16) begin : g_width_check
    $error("hack_alu_arbiter supports WIDTH=16 only");
  end

  state_t           state_reg;
  logic             last_grant_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [5:0]       ctl_reg;
  logic             id_reg;
  logic             any_valid, grant_id;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zr, alu_ng;

  assign any_valid = req0_valid | req1_valid;

  // On a tie, round-robin hands the grant to whoever did not win last time.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid)
      grant_id = FIXED_PRIO ? 1'b0 : ~last_grant_reg;
    else if (req1_valid)
      grant_id = 1'b1;
  end

  assign req0_ready = (state_reg == IDLE) && any_valid && !grant_id;
  assign req1_ready = (state_reg == IDLE) && any_valid && grant_id;
  assign busy       = (state_reg != IDLE);

  hack_alu16 u_alu (
    .x   (a_reg),
    .y   (b_reg),
    .ctl (ctl_reg),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      a_reg          <= '0;
      b_reg          <= '0;
      ctl_reg        <= '0;
      id_reg         <= 1'b0;
      resp_valid     <= 1'b0;
      resp_id        <= 1'b0;
      resp_out       <= '0;
      resp_zr        <= 1'b0;
      resp_ng        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (any_valid) begin
          a_reg          <= grant_id ? req1_a : req0_a;
          b_reg          <= grant_id ? req1_b : req0_b;
          ctl_reg        <= grant_id ? req1_ctl : req0_ctl;
          id_reg         <= grant_id;
          last_grant_reg <= grant_id;
          state_reg      <= EXEC;
        end
        EXEC: begin
          resp_out   <= alu_out;
          resp_zr    <= alu_zr;
          resp_ng    <= alu_ng;
          resp_id    <= id_reg;
          resp_valid <= 1'b1;
          state_reg  <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_alu_arbiter.sv
// Directed bench for hack_alu_arbiter: one round-robin instance exercised scenario by
// scenario, plus a fixed-priority instance for the tie-break check.
module tb_hack_alu_arbiter;
  import hack_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]  req0_ctl, req1_ctl;
  logic        resp_valid, resp_ready, resp_id, resp_zr, resp_ng, busy;
  logic [15:0] resp_out;

  logic        f_req0_valid, f_req1_valid, f_req0_ready, f_req1_ready;
  logic [15:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
  logic [5:0]  f_req0_ctl, f_req1_ctl;
  logic        f_resp_valid, f_resp_ready, f_resp_id, f_resp_zr, f_resp_ng, f_busy;
  logic [15:0] f_resp_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hack_alu_arbiter #(.WIDTH(16), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_out(resp_out),
    .resp_zr(resp_zr), .resp_ng(resp_ng), .busy(busy)
  );

  hack_alu_arbiter #(.WIDTH(16), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a), .req0_b(f_req0_b), .req0_ctl(f_req0_ctl),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a), .req1_b(f_req1_b), .req1_ctl(f_req1_ctl),
    .resp_valid(f_resp_valid), .resp_ready(f_resp_ready), .resp_id(f_resp_id), .resp_out(f_resp_out),
    .resp_zr(f_resp_zr), .resp_ng(f_resp_ng), .busy(f_busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Drive one request and hold it until the DUT shows ready (bounded); returns just after the accepting edge.
  task automatic issue(input bit r, input logic [15:0] a, input logic [15:0] b,
                       input logic [5:0] c, output bit ok);
    ok = 1'b0;
    if (r) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctl = c; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctl = c; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_resp(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin ok = 1'b1; break; end
    end
    $display("resp id=%0d out=%h zr=%0d ng=%0d after %0d cycles", resp_id, resp_out, resp_zr, resp_ng, cyc);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_state got valid=%b busy=%b exp 0 0", resp_valid, busy); end
    checks++; if (resp_out !== 16'h0000 || resp_id !== 1'b0 || resp_zr !== 1'b0 || resp_ng !== 1'b0) begin errors++; $display("FAIL reset_outputs got out=%h id=%b zr=%b ng=%b exp all 0", resp_out, resp_id, resp_zr, resp_ng); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit ok; int cyc;
    issue(1'b0, 16'h1234, 16'hABCD, OP_AND, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_ready got no ready exp ready"); end
    checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL single_exec got busy=%b valid=%b exp 1 0", busy, resp_valid); end
    wait_resp(ok, cyc);
    checks++; if (!ok || cyc != 2) begin errors++; $display("FAIL single_latency got ok=%b cycles=%0d exp 1 2", ok, cyc); end
    checks++; if (resp_out !== 16'h0204 || resp_id !== 1'b0 || resp_zr !== 1'b0 || resp_ng !== 1'b0) begin errors++; $display("FAIL single_and got out=%h id=%b zr=%b ng=%b exp 0204 0 0 0", resp_out, resp_id, resp_zr, resp_ng); end
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    bit ok; int cyc;
    issue(1'b0, 16'hFFFF, 16'h0001, OP_ADD, ok);
    wait_resp(ok, cyc);
    checks++; if (!ok || resp_out !== 16'h0000 || resp_zr !== 1'b1 || resp_ng !== 1'b0 || resp_id !== 1'b0) begin errors++; $display("FAIL arith_add_wrap got out=%h zr=%b ng=%b id=%b exp 0000 1 0 0", resp_out, resp_zr, resp_ng, resp_id); end
    @(posedge clk); #1;
    issue(1'b1, 16'h0005, 16'h0007, OP_SUB, ok);
    wait_resp(ok, cyc);
    checks++; if (!ok || resp_out !== 16'hFFFE || resp_zr !== 1'b0 || resp_ng !== 1'b1 || resp_id !== 1'b1) begin errors++; $display("FAIL arith_sub got out=%h zr=%b ng=%b id=%b exp fffe 0 1 1", resp_out, resp_zr, resp_ng, resp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic [15:0] a0[3], b0[3], e0[3], a1[3], b1[3], e1[3];
    logic [5:0]  c0[3], c1[3];
    logic [15:0] exp_out;
    logic        exp_id;
    int k0, k1, cyc;
    bit ok;
    a0 = '{16'h00F0, 16'h1111, 16'h000A}; b0 = '{16'h0F0F, 16'h2222, 16'h0000};
    c0 = '{OP_ADD, OP_AND, OP_NEG1};      e0 = '{16'h0FFF, 16'h0000, 16'hFFFF};
    a1 = '{16'h0010, 16'h8000, 16'h0003}; b1 = '{16'h0003, 16'h0000, 16'h0003};
    c1 = '{OP_SUB, OP_ADD, OP_ADD};       e1 = '{16'h000D, 16'h8000, 16'h0006};
    k0 = 0; k1 = 0;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = a0[0]; req0_b = b0[0]; req0_ctl = c0[0];
    req1_valid = 1'b1; req1_a = a1[0]; req1_b = b1[0]; req1_ctl = c1[0];
    for (int i = 0; i < 4; i++) begin
      exp_id = i[0];
      @(negedge clk);
      checks++; if (req0_ready !== !exp_id || req1_ready !== exp_id) begin errors++; $display("FAIL rr_grant%0d got ready=%b%b exp grant %0d", i, req1_ready, req0_ready, exp_id); end
      exp_out = exp_id ? e1[k1] : e0[k0];
      @(posedge clk); #1;
      if (exp_id) begin k1++; req1_a = a1[k1]; req1_b = b1[k1]; req1_ctl = c1[k1]; end
      else        begin k0++; req0_a = a0[k0]; req0_b = b0[k0]; req0_ctl = c0[k0]; end
      wait_resp(ok, cyc);
      checks++; if (!ok || resp_id !== exp_id || resp_out !== exp_out) begin errors++; $display("FAIL rr_result%0d got id=%b out=%h exp %b %h", i, resp_id, resp_out, exp_id, exp_out); end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok; int cyc;
    resp_ready = 1'b0;
    issue(1'b0, 16'h00FF, 16'h0F0F, OP_AND, ok);
    req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0001; req1_ctl = OP_ADD;
    wait_resp(ok, cyc);
    checks++; if (!ok) begin errors++; $display("FAIL bp_resp got no resp_valid exp resp_valid"); end
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_out !== 16'h000F || resp_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1)
        begin errors++; $display("FAIL bp_hold%0d got valid=%b out=%h id=%b ready=%b%b busy=%b exp 1 000f 0 00 1", j, resp_valid, resp_out, resp_id, req1_ready, req0_ready, busy); end
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_release got valid=%b exp 1", resp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL bp_next_grant got valid=%b req1_ready=%b exp 0 1", resp_valid, req1_ready); end
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_resp(ok, cyc);
    checks++; if (!ok || resp_out !== 16'h0002 || resp_id !== 1'b1) begin errors++; $display("FAIL bp_second got out=%h id=%b exp 0002 1", resp_out, resp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok, seen; int cyc;
    issue(1'b1, 16'h0003, 16'h0004, OP_ADD, ok);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_exec got valid=%b busy=%b exp 0 0", resp_valid, busy); end
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_exec_noresp got resp_valid seen exp none"); end
    @(posedge clk); #1 resp_ready = 1'b0;
    issue(1'b0, 16'h0009, 16'h0001, OP_ADD, ok);
    wait_resp(ok, cyc);
    checks++; if (!ok || resp_out !== 16'h000A) begin errors++; $display("FAIL rst_resp_setup got out=%h exp 000a", resp_out); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_out !== 16'h0000) begin errors++; $display("FAIL rst_resp got valid=%b busy=%b out=%h exp 0 0 0000", resp_valid, busy, resp_out); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 16'h0100; req0_b = 16'h0011; req0_ctl = OP_ADD;
    req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0001; req1_ctl = OP_AND;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_first_grant got ready=%b%b exp req0", req1_ready, req0_ready); end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(ok, cyc);
    checks++; if (!ok || resp_out !== 16'h0111 || resp_id !== 1'b0) begin errors++; $display("FAIL rst_after got out=%h id=%b exp 0111 0", resp_out, resp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_const();
    bit ok; int cyc;
    issue(1'b0, 16'h1234, 16'h5678, OP_NEG1, ok);
    wait_resp(ok, cyc);
    checks++; if (!ok || resp_out !== 16'hFFFF || resp_ng !== 1'b1 || resp_zr !== 1'b0) begin errors++; $display("FAIL const_neg1 got out=%h ng=%b zr=%b exp ffff 1 0", resp_out, resp_ng, resp_zr); end
    @(posedge clk); #1;
    issue(1'b1, 16'h9999, 16'h7777, 6'b101010, ok);
    wait_resp(ok, cyc);
    checks++; if (!ok || resp_out !== 16'h0000 || resp_zr !== 1'b1 || resp_ng !== 1'b0) begin errors++; $display("FAIL const_zero got out=%h zr=%b ng=%b exp 0000 1 0", resp_out, resp_zr, resp_ng); end
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_prio();
    bit ok;
    f_resp_ready = 1'b1;
    f_req0_valid = 1'b1; f_req0_a = 16'h0003; f_req0_b = 16'h0004; f_req0_ctl = OP_ADD;
    f_req1_valid = 1'b1; f_req1_a = 16'h0009; f_req1_b = 16'h0001; f_req1_ctl = OP_ADD;
    for (int n = 0; n < 3; n++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (f_resp_valid) begin ok = 1'b1; break; end
      end
      $display("fp resp id=%0d out=%h", f_resp_id, f_resp_out);
      checks++; if (!ok || f_resp_id !== 1'b0 || f_resp_out !== 16'h0007) begin errors++; $display("FAIL fp_grant%0d got ok=%b id=%b out=%h exp 1 0 0007", n, ok, f_resp_id, f_resp_out); end
      @(posedge clk); #1;
    end
    f_req0_valid = 1'b0;
    f_req1_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctl = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctl = '0;
    resp_ready = 1'b0;
    f_req0_valid = 1'b0; f_req0_a = '0; f_req0_b = '0; f_req0_ctl = '0;
    f_req1_valid = 1'b0; f_req1_a = '0; f_req1_b = '0; f_req1_ctl = '0;
    f_resp_ready = 1'b0;
    #1;
    test_reset();
    resp_ready = 1'b1;
    test_single();
    test_arith();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_const();
    test_fixed_prio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
